counter_step_ctrl: RTL and testbench
====================================

// Module: counter_step_ctrl
// PURPOSE
//  Front-end control stage for the 4-bit up/down counter. Turns raw board buttons into the
//  counter's upDown level and a one-cycle step enable at a fixed rate.
//  Synchronises and debounces each button and detects presses. A STOP/RUN machine gates the stepping.
//  Sits directly upstream of the counter: drives its upDown input and qualifies its count step.
// PARAMETERS
//  DB_CYCLES  500000    consecutive stable synchronised samples required to accept a button level
//  TICK_DIV   50000000  clock cycles between step pulses while running (>=2)
// PORTS
//  clock       in   1  single clock; all logic on posedge clock
//  reset       in   1  synchronous, active-high reset
//  btn_dir     in   1  raw asynchronous button; press toggles direction
//  btn_run     in   1  raw asynchronous button; press toggles STOP/RUN
//  btn_step    in   1  raw single-step button (present only with SINGLE_STEP_EN)
//  upDown      out  1  direction to counter: 1 = up, 0 = down
//  step        out  1  one-cycle count-enable pulse
//  running     out  1  1 while in RUN state
//  dir_chg     out  1  one-cycle pulse, registered with the upDown change
// BEHAVIOUR
//  Reset values: upDown=1, step=0, running=0, dir_chg=0, state=ST_STOP, prescaler=0.
//  Debounced levels reset to 0 and all synchroniser flops clear.
//  Button path, per input:
//   - 2-flop synchroniser.
//   - Debounce counter: clears whenever the synced value equals the debounced level.
//   - Debounced level flips after DB_CYCLES consecutive differing samples.
//   - Press pulse: 1 cycle on the debounced 0->1 edge.
//   - Latency: raw rise stable from cycle k -> press pulse at cycle k+DB_CYCLES+3.
//   - Release and glitches shorter than DB_CYCLES produce no pulse.
//  FSM states:
//   - ST_STOP: run press -> ST_RUN and prescaler cleared.
//   - ST_RUN: run press -> ST_STOP; prescaler held at 0, no further step.
//  Prescaler (ST_RUN only):
//   - Counts 0..TICK_DIV-1 and wraps to 0.
//   - step=1 exactly in the cycle after prescaler==TICK_DIV-1.
//   - First step comes TICK_DIV cycles after RUN entry.
//  Dir press (any state):
//   - upDown inverts and dir_chg=1 the next cycle.
//   - Prescaler cleared, so step never coincides with an upDown change.
//  Simultaneous events:
//   - Dir and run presses in the same cycle are both applied; the prescaler clears once.
//   - A step due in the same cycle as a dir or run press is suppressed.
//  Reset mid-operation: returns to reset values on the next edge; in-flight debounce counts are discarded.
//  Prescaler width: $clog2(TICK_DIV); no overflow; DB counter saturates at DB_CYCLES.
// CONFIGURATION
//  SINGLE_STEP_EN defined:
//   - btn_step port exists, with its own debounce path.
//   - A press in ST_STOP emits exactly one step pulse one cycle later.
//   - A press in ST_RUN is ignored.
//  SINGLE_STEP_EN undefined: btn_step port is absent and step originates only from the prescaler.
// STRUCTURE
//  counter_pkg holds:
//   - typedef enum logic [0:0] {ST_STOP, ST_RUN} run_state_t.
//   - Localparams UP=1'b1, DOWN=1'b0.
//  Sub-module button_debounce #(DB_CYCLES) (clock, reset, raw, level, press):
//   - Holds synchroniser, debounce counter and edge detect.
//   - One instance per button.
//  Top level: FSM, direction register, prescaler, output registers.
// TESTING (bench params DB_CYCLES=4, TICK_DIV=8)
//  1 Reset held 3 cycles -> upDown=1, step=0, running=0, dir_chg=0.
//  2 btn_run high from cycle 10 -> press at 17, running=1 at 18; steps at 26, 34, 42, each 1 cycle.
//  3 btn_dir pulses 1-3 cycles long (glitch) -> no dir_chg.
//    Held 10 cycles while running -> upDown 1->0 with dir_chg; next step exactly 8 cycles later.
//  4 btn_run and btn_dir presses in the same cycle while running -> running=0, upDown toggled, no further step.
//  5 Reset asserted 3 cycles after RUN entry -> state and outputs back to reset values next edge.
//    No step until a new run press.
//  6 SINGLE_STEP_EN:
//    - btn_step press in ST_STOP -> exactly one step pulse.
//    - Same press in ST_RUN -> no extra step.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down counter front end.
package counter_pkg;

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-flop synchroniser, saturating debounce counter and
// registered rising-edge press detect on the debounced level.
module button_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Synchronise, debounce and detect the debounced 0->1 edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // A full run of differing samples flips the level; any agreeing sample restarts the run.
            if (cnt == CNT_MAX) begin
                level <= ~level;
                cnt   <= '0;
            end else if (sync2 != level) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/counter_step_ctrl.sv
// Button front end for the 4-bit up/down counter: STOP/RUN machine, direction
// register and step prescaler. Define SINGLE_STEP_EN to add the btn_step input.
module counter_step_ctrl
    import counter_pkg::*;
#(
    parameter int DB_CYCLES = 500000,
    parameter int TICK_DIV  = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_dir,
    input  logic btn_run,
`ifdef SINGLE_STEP_EN
    input  logic btn_step,
`endif
    output logic upDown,
    output logic step,
    output logic running,
    output logic dir_chg
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    run_state_t         state;
    run_state_t         state_nxt;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_nxt;
    logic               updown_nxt;
    logic               step_nxt;
    logic               dir_chg_nxt;

    logic dir_level;
    logic dir_press;
    logic run_level;
    logic run_press;
    logic unused_levels;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_dir_db (
        .clock (clock),
        .reset (reset),
        .raw   (btn_dir),
        .level (dir_level),
        .press (dir_press)
    );

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
        .clock (clock),
        .reset (reset),
        .raw   (btn_run),
        .level (run_level),
        .press (run_press)
    );

`ifdef SINGLE_STEP_EN
    logic step_level;
    logic step_press;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clock (clock),
        .reset (reset),
        .raw   (btn_step),
        .level (step_level),
        .press (step_press)
    );

    assign unused_levels = ^{dir_level, run_level, step_level};
`else
    assign unused_levels = ^{dir_level, run_level};
`endif

    // STOP/RUN state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, prescaler and output decisions.
    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        updown_nxt  = upDown;
        step_nxt    = 1'b0;
        dir_chg_nxt = 1'b0;

        case (state)
            ST_STOP: begin
                if (run_press) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_STOP;
                end
            end
            ST_RUN: begin
                if (run_press) begin
                    state_nxt = ST_STOP;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_STOP;
            end
        endcase

        if (dir_press) begin
            updown_nxt  = ~upDown;
            dir_chg_nxt = 1'b1;
        end else begin
            updown_nxt  = upDown;
            dir_chg_nxt = 1'b0;
        end

        // Any press restarts the tick period, which also drops a step due this cycle.
        if (run_press || dir_press) begin
            presc_nxt = '0;
        end else if (state == ST_RUN) begin
            if (presc == PRESC_MAX) begin
                presc_nxt = '0;
                step_nxt  = 1'b1;
            end else begin
                presc_nxt = presc + PRESC_W'(1);
            end
        end else begin
            presc_nxt = '0;
        end

`ifdef SINGLE_STEP_EN
        if (step_press && (state == ST_STOP) && !run_press && !dir_press) begin
            step_nxt = 1'b1;
        end else begin
            step_nxt = step_nxt;
        end
`endif
    end

    // Prescaler and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc   <= '0;
            upDown  <= UP;
            step    <= 1'b0;
            running <= 1'b0;
            dir_chg <= 1'b0;
        end else begin
            presc   <= presc_nxt;
            upDown  <= updown_nxt;
            step    <= step_nxt;
            running <= (state_nxt == ST_RUN);
            dir_chg <= dir_chg_nxt;
        end
    end

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Directed bench for counter_step_ctrl with DB_CYCLES=4, TICK_DIV=8.
module tb_counter_step_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn_dir = 1'b0;
    logic btn_run = 1'b0;
`ifdef SINGLE_STEP_EN
    logic btn_step = 1'b0;
`endif
    logic upDown;
    logic step;
    logic running;
    logic dir_chg;

    int total = 0;
    int bad   = 0;

    counter_step_ctrl #(.DB_CYCLES(4), .TICK_DIV(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .btn_dir (btn_dir),
        .btn_run (btn_run),
`ifdef SINGLE_STEP_EN
        .btn_step(btn_step),
`endif
        .upDown  (upDown),
        .step    (step),
        .running (running),
        .dir_chg (dir_chg)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset   = 1'b1;
        btn_dir = 1'b0;
        btn_run = 1'b0;
`ifdef SINGLE_STEP_EN
        btn_step = 1'b0;
`endif
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    // Returns at the first negedge with running=1 (RUN entered at the preceding posedge).
    task automatic start_run();
        btn_run = 1'b1;
        repeat (5) @(negedge clock);
        btn_run = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn_dir = 1'b0;
        btn_run = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (upDown !== 1'b1)  begin bad++; $display("FAIL reset_updown got=%b want=1", upDown); end
        total++; if (step !== 1'b0)    begin bad++; $display("FAIL reset_step got=%b want=0", step); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
        total++; if (dir_chg !== 1'b0) begin bad++; $display("FAIL reset_dir_chg got=%b want=0", dir_chg); end
        reset = 1'b0;
    endtask

    task automatic test_run();
        logic exp_step;
        logic exp_run;
        do_reset();
        btn_run = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clock);
            exp_run  = (j >= 9);
            exp_step = (j == 17) || (j == 25) || (j == 33);
            total++; if (running !== exp_run) begin bad++; $display("FAIL run_running j=%0d got=%b want=%b", j, running, exp_run); end
            total++; if (step !== exp_step)   begin bad++; $display("FAIL run_step j=%0d got=%b want=%b", j, step, exp_step); end
            if (j == 5) btn_run = 1'b0;
        end
    endtask

    task automatic test_dir_glitch();
        do_reset();
        for (int len = 1; len <= 3; len++) begin
            btn_dir = 1'b1;
            repeat (len) @(negedge clock);
            btn_dir = 1'b0;
            for (int j = 1; j <= 12; j++) begin
                @(negedge clock);
                total++; if (dir_chg !== 1'b0) begin bad++; $display("FAIL glitch_dir_chg len=%0d j=%0d got=%b want=0", len, j, dir_chg); end
                total++; if (upDown !== 1'b1)  begin bad++; $display("FAIL glitch_updown len=%0d j=%0d got=%b want=1", len, j, upDown); end
            end
        end
    endtask

    task automatic test_dir_run();
        logic exp_step;
        logic exp_ud;
        logic exp_chg;
        do_reset();
        start_run();
        btn_dir = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clock);
            exp_step = (j == 8) || (j == 17) || (j == 25);
            exp_ud   = (j < 9);
            exp_chg  = (j == 9);
            total++; if (step !== exp_step)  begin bad++; $display("FAIL dir_step j=%0d got=%b want=%b", j, step, exp_step); end
            total++; if (upDown !== exp_ud)  begin bad++; $display("FAIL dir_updown j=%0d got=%b want=%b", j, upDown, exp_ud); end
            total++; if (dir_chg !== exp_chg) begin bad++; $display("FAIL dir_chg j=%0d got=%b want=%b", j, dir_chg, exp_chg); end
            total++; if (running !== 1'b1)   begin bad++; $display("FAIL dir_running j=%0d got=%b want=1", j, running); end
            if (j == 10) btn_dir = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        logic exp_step;
        logic exp_run;
        logic exp_chg;
        do_reset();
        start_run();
        repeat (4) @(negedge clock);
        btn_run = 1'b1;
        btn_dir = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clock);
            exp_step = (j == 4);
            exp_run  = (j < 9);
            exp_chg  = (j == 9);
            total++; if (step !== exp_step)   begin bad++; $display("FAIL simul_step j=%0d got=%b want=%b", j, step, exp_step); end
            total++; if (running !== exp_run) begin bad++; $display("FAIL simul_running j=%0d got=%b want=%b", j, running, exp_run); end
            total++; if (upDown !== exp_run)  begin bad++; $display("FAIL simul_updown j=%0d got=%b want=%b", j, upDown, exp_run); end
            total++; if (dir_chg !== exp_chg) begin bad++; $display("FAIL simul_dir_chg j=%0d got=%b want=%b", j, dir_chg, exp_chg); end
            if (j == 5) begin
                btn_run = 1'b0;
                btn_dir = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_run();
        repeat (2) @(negedge clock);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL mid_pre_running got=%b want=1", running); end
        reset = 1'b1;
        @(negedge clock);
        total++; if (running !== 1'b0) begin bad++; $display("FAIL mid_running got=%b want=0", running); end
        total++; if (step !== 1'b0)    begin bad++; $display("FAIL mid_step got=%b want=0", step); end
        total++; if (upDown !== 1'b1)  begin bad++; $display("FAIL mid_updown got=%b want=1", upDown); end
        total++; if (dir_chg !== 1'b0) begin bad++; $display("FAIL mid_dir_chg got=%b want=0", dir_chg); end
        reset = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clock);
            total++; if (step !== 1'b0)    begin bad++; $display("FAIL mid_after_step j=%0d got=%b want=0", j, step); end
            total++; if (running !== 1'b0) begin bad++; $display("FAIL mid_after_running j=%0d got=%b want=0", j, running); end
        end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        logic exp_step;
        do_reset();
        btn_step = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clock);
            exp_step = (j == 9);
            total++; if (step !== exp_step) begin bad++; $display("FAIL sstep_stop j=%0d got=%b want=%b", j, step, exp_step); end
            if (j == 5) btn_step = 1'b0;
        end
        start_run();
        btn_step = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clock);
            exp_step = (j == 8) || (j == 16);
            total++; if (step !== exp_step) begin bad++; $display("FAIL sstep_run j=%0d got=%b want=%b", j, step, exp_step); end
            if (j == 5) btn_step = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_dir_glitch();
        test_dir_run();
        test_simultaneous();
        test_reset_mid();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
